// File: rtl/uart_tx_engine.sv
// UART transmit engine: a 1-entry holding register (THR) feeding a start/data/parity/stop
// serializer. One serial bit lasts OVERSAMPLE baud ticks; a baud tick occurs every {DLH,DLL} clocks.
module uart_tx_engine #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_flag,
  input  logic [7:0] TBR,
  input  logic [7:0] LCR,
  input  logic [7:0] DLL,
  input  logic [7:0] DLH,
  output logic       tx,
  output logic       thr_empty,
  output logic       tsr_empty,
  output logic       tx_done,
  output logic       tx_ovr
);

  localparam int unsigned OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity over the low 5+wlen data bits; stick mode forces the bit to ~eps.
  function automatic logic frame_parity(input logic [7:0] data, input logic [1:0] wlen,
                                        input logic eps, input logic stick);
    logic [7:0] mask;
    logic       odd;
    mask = 8'hFF >> (2'd3 - wlen);
    odd  = ^(data & mask);
    if (stick) begin
      frame_parity = ~eps;
    end else if (eps) begin
      frame_parity = odd;
    end else begin
      frame_parity = ~odd;
    end
  endfunction

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [OS_W-1:0] os_q, os_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [7:0]      thr_q, thr_d;
  logic            thr_empty_q, thr_empty_d;
  logic [15:0]     div_q, div_d;
  logic [3:0]      lcr_q, lcr_d;
  logic            tx_q, tx_d;
  logic            tsr_empty_q, tsr_empty_d;
  logic            tx_done_q, tx_done_d;
  logic            tx_ovr_q, tx_ovr_d;

  logic [15:0] div_in;
  logic        tick, bit_end, last_data, last_stop, load, frame_bit;
  logic        lcr_unused;

  assign lcr_unused = LCR[7];

  // Next-state, baud/bit counters, THR handshake and serial bit selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    os_d        = os_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    thr_d       = thr_q;
    thr_empty_d = thr_empty_q;
    div_d       = div_q;
    lcr_d       = lcr_q;
    tx_done_d   = 1'b0;
    tx_ovr_d    = 1'b0;
    load        = 1'b0;
    frame_bit   = 1'b1;
    div_in      = {DLH, DLL};
    tick        = (cnt_q == div_q - 16'd1);
    bit_end     = tick && (os_q == OS_LAST);
    last_data   = (bit_q == {1'b1, lcr_q[1:0]});
    last_stop   = (bit_q == {2'b00, lcr_q[2]});

    if (tick) begin
      cnt_d = 16'd0;
      os_d  = bit_end ? {OS_W{1'b0}} : os_q + OS_W'(1);
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        frame_bit = 1'b1;
        cnt_d     = 16'd0;
        os_d      = {OS_W{1'b0}};
        bit_d     = 3'd0;
        if (!thr_empty_q) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        frame_bit = 1'b0;
        if (bit_end) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        frame_bit = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (last_data) begin
            bit_d   = 3'd0;
            state_d = lcr_q[3] ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        frame_bit = par_q;
        if (bit_end) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        frame_bit = 1'b1;
        if (bit_end && last_stop) begin
          tx_done_d = 1'b1;
          bit_d     = 3'd0;
          if (!thr_empty_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (bit_end) begin
          bit_d = bit_q + 3'd1;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        frame_bit = 1'b1;
        state_d   = IDLE;
      end
    endcase

    // Frame start (from IDLE or straight out of STOP) snapshots the configuration.
    if (load) begin
      state_d     = START;
      shift_d     = thr_q;
      par_d       = frame_parity(thr_q, LCR[1:0], LCR[4], LCR[5]);
      div_d       = (div_in == 16'd0) ? 16'd1 : div_in;
      lcr_d       = LCR[3:0];
      cnt_d       = 16'd0;
      os_d        = {OS_W{1'b0}};
      bit_d       = 3'd0;
      thr_empty_d = 1'b1;
    end else begin
      thr_empty_d = thr_empty_q;
    end

    if (tx_flag) begin
      if (thr_empty_q || load) begin
        thr_d       = TBR;
        thr_empty_d = 1'b0;
      end else begin
        tx_ovr_d = 1'b1;
      end
    end else begin
      thr_d = thr_q;
    end

    tx_d        = LCR[6] ? 1'b0 : frame_bit;
    tsr_empty_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      os_q        <= {OS_W{1'b0}};
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      par_q       <= 1'b0;
      thr_q       <= 8'd0;
      thr_empty_q <= 1'b1;
      div_q       <= 16'd1;
      lcr_q       <= 4'd0;
      tx_q        <= 1'b1;
      tsr_empty_q <= 1'b1;
      tx_done_q   <= 1'b0;
      tx_ovr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      os_q        <= os_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      thr_q       <= thr_d;
      thr_empty_q <= thr_empty_d;
      div_q       <= div_d;
      lcr_q       <= lcr_d;
      tx_q        <= tx_d;
      tsr_empty_q <= tsr_empty_d;
      tx_done_q   <= tx_done_d;
      tx_ovr_q    <= tx_ovr_d;
    end
  end

  assign tx        = tx_q;
  assign thr_empty = thr_empty_q;
  assign tsr_empty = tsr_empty_q;
  assign tx_done   = tx_done_q;
  assign tx_ovr    = tx_ovr_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus pushes hand-computed frames, a negedge monitor
// checks every clock of each frame on tx plus the tx_done pulse position.
`timescale 1ns/1ps
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_flag;
  logic [7:0] TBR, LCR, DLL, DLH;
  logic       tx, thr_empty, tsr_empty, tx_done, tx_ovr;

  uart_tx_engine #(.OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .tx_flag(tx_flag), .TBR(TBR), .LCR(LCR), .DLL(DLL), .DLH(DLH),
    .tx(tx), .thr_empty(thr_empty), .tsr_empty(tsr_empty), .tx_done(tx_done), .tx_ovr(tx_ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bits[k] is serial bit k (bit 0 = start); lo..hi-1 are frame clocks forced low by break.
  typedef struct {
    logic [15:0] bits;
    int          nb;
    int          bw;
    int          start;
    int          lo;
    int          hi;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_busy = 1'b0;
  bit   allow_low = 1'b0;
  bit   unexp_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flag(input logic [7:0] b, output int e0);
    step();
    TBR     = b;
    tx_flag = 1'b1;
    step();
    tx_flag = 1'b0;
    e0      = cyc;
  endtask

  task automatic push(input logic [15:0] bits, input int nb, input int bw, input int start,
                      input int lo, input int hi, input int id);
    exp_t e;
    e.bits = bits; e.nb = nb; e.bw = bw; e.start = start; e.lo = lo; e.hi = hi; e.id = id;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || mon_busy) && t < 5000) begin
      step();
      t++;
    end
    chk("monitor_drain_in_time", (t < 5000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin : monitor
    exp_t e;
    int   t, len, bad_at, done_at;
    logic req_tx, expb;
    forever begin
      @(negedge clk);
      if (sb.size() == 0) begin
        mon_busy = 1'b0;
        if (!rst && !allow_low && tx === 1'b0 && !unexp_seen) begin
          unexp_seen = 1'b1;
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame: tx=0 at cycle %0d, required idle 1", cyc);
        end
      end else begin
        mon_busy = 1'b1;
        e = sb.pop_front();
        t = 0;
        while (tx !== 1'b0 && t < 3000) begin
          @(negedge clk);
          t++;
        end
        if (tx !== 1'b0) begin
          n_cmp++;
          n_err++;
          $display("FAIL frame%0d_start: got no start bit in 3000 cycles, required one", e.id);
        end else begin
          if (e.start >= 0) chk($sformatf("frame%0d_start_cycle", e.id), cyc, e.start);
          len = e.nb * e.bw; bad_at = -1; done_at = -1; req_tx = 1'b0;
          for (int j = 0; j < len; j++) begin
            if (j > 0) @(negedge clk);
            expb = (j >= e.lo && j < e.hi) ? 1'b0 : e.bits[j / e.bw];
            if (tx !== expb && bad_at < 0) begin
              bad_at = j;
              req_tx = expb;
            end
            if (tx_done !== (j == len - 1) && done_at < 0) done_at = j;
          end
          n_cmp++;
          if (bad_at >= 0) begin
            n_err++;
            $display("FAIL frame%0d_tx: frame clock %0d got %b required %b", e.id, bad_at, ~req_tx, req_tx);
          end
          n_cmp++;
          if (done_at >= 0) begin
            n_err++;
            $display("FAIL frame%0d_tx_done: got wrong tx_done at frame clock %0d, required pulse only at %0d",
                     e.id, done_at, len - 1);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int  e0, e1, e2, s1;
    bit  bad;
    rst = 1'b1; tx_flag = 1'b0; TBR = 8'h00; LCR = 8'h03; DLL = 8'h01; DLH = 8'h00;
    repeat (3) step();
    chk("reset_tx", tx, 32'd1);
    chk("reset_thr_empty", thr_empty, 32'd1);
    chk("reset_tsr_empty", tsr_empty, 32'd1);
    chk("reset_tx_done", tx_done, 32'd0);
    chk("reset_tx_ovr", tx_ovr, 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // 8N1, div 1, A5
    do_flag(8'hA5, e0);
    push(16'h034A, 10, 16, e0 + 2, 0, 0, 1);
    chk("t1_thr_full_after_flag", thr_empty, 32'd0);
    chk("t1_tsr_idle_at_flag", tsr_empty, 32'd1);
    step();
    chk("t1_thr_empty_after_load", thr_empty, 32'd1);
    chk("t1_tsr_busy_after_load", tsr_empty, 32'd0);
    wait_idle();

    // 7E2, div 2, C1
    LCR = 8'h1E; DLL = 8'h02;
    do_flag(8'hC1, e0);
    push(16'h0682, 11, 32, e0 + 2, 0, 0, 2);
    wait_idle();

    // back-to-back 55 then AA
    LCR = 8'h03; DLL = 8'h01;
    do_flag(8'h55, e0);
    s1 = e0 + 2;
    push(16'h02AA, 10, 16, s1, 0, 0, 3);
    repeat (40) step();
    do_flag(8'hAA, e1);
    push(16'h0354, 10, 16, s1 + 160, 0, 0, 4);
    chk("t3_no_ovr", tx_ovr, 32'd0);
    while (cyc < s1 + 158) step();
    chk("t3_thr_full_before_handoff", thr_empty, 32'd0);
    step();
    chk("t3_thr_empty_at_handoff", thr_empty, 32'd1);
    chk("t3_tsr_busy_at_handoff", tsr_empty, 32'd0);
    wait_idle();

    // overrun: 11, 22, 33 within one frame
    do_flag(8'h11, e0);
    push(16'h0222, 10, 16, e0 + 2, 0, 0, 5);
    repeat (10) step();
    do_flag(8'h22, e1);
    push(16'h0244, 10, 16, e0 + 2 + 160, 0, 0, 6);
    repeat (10) step();
    do_flag(8'h33, e2);
    chk("t4_ovr_pulse", tx_ovr, 32'd1);
    step();
    chk("t4_ovr_pulse_end", tx_ovr, 32'd0);
    wait_idle();
    chk("t4_no_third_frame", tsr_empty, 32'd1);

    // reset mid-DATA with THR also full
    allow_low = 1'b1;
    do_flag(8'h00, e0);
    repeat (18) step();
    do_flag(8'h77, e1);
    while (cyc < e0 + 50) step();
    chk("t5_tx_low_before_reset", tx, 32'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_tx_async_reset", tx, 32'd1);
    chk("t5_tsr_async_reset", tsr_empty, 32'd1);
    chk("t5_thr_async_reset", thr_empty, 32'd1);
    chk("t5_tx_done_async_reset", tx_done, 32'd0);
    repeat (3) step();
    rst = 1'b0;
    allow_low = 1'b0;
    bad = 1'b0;
    repeat (200) begin
      step();
      if (tx_done !== 1'b0 || tx !== 1'b1) bad = 1'b1;
    end
    chk("t5_quiet_after_reset", bad, 32'd0);
    do_flag(8'h3C, e0);
    push(16'h0278, 10, 16, e0 + 2, 0, 0, 7);
    wait_idle();

    // break mid-frame, then DLL change that must only affect the next frame
    do_flag(8'h0F, e0);
    push(16'h021E, 10, 16, e0 + 2, 29, 59, 8);
    while (cyc < e0 + 30) step();
    LCR = 8'h43;
    while (cyc < e0 + 60) step();
    LCR = 8'h03;
    while (cyc < e0 + 80) step();
    DLL = 8'h02;
    wait_idle();

    // 5O1 at div 2, FF
    LCR = 8'h08;
    do_flag(8'hFF, e1);
    push(16'h00BE, 8, 32, e1 + 2, 0, 0, 9);
    wait_idle();

    // divisor 0 behaves as 1
    LCR = 8'h03; DLL = 8'h00; DLH = 8'h00;
    do_flag(8'h81, e2);
    push(16'h0302, 10, 16, e2 + 2, 0, 0, 10);
    wait_idle();

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
